// File: rtl/text_renderer.sv
// Character-mode pixel generator for the 800x600 path: 8x16 cells fetched from text RAM
// and font ROM, three pix_en strobes from timing inputs to colour/sync outputs.
module text_renderer #(
    parameter int COLS         = 100,
    parameter int ROWS         = 37,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        pix_en,
    input  logic [15:0] hcount,
    input  logic [15:0] vcount,
    input  logic        hvis,
    input  logic        vvis,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        text_re,
    output logic [11:0] text_addr,
    input  logic [15:0] text_data,
    output logic        font_re,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [5:0]  cursor_row,
    output logic [3:0]  colour,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        vis_out
);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    function automatic logic [3:0] pick_colour(input logic in_text, input logic pixel,
                                               input logic [3:0] fg, input logic [3:0] bg);
        if (!in_text)
            return 4'd0;
        return pixel ? fg : bg;
    endfunction

    logic [12:0] col;
    logic [11:0] row;
    logic [3:0]  line;
    logic        in_text;
    logic        hit;

    logic        vld_p0, vis_p0, hs_p0, vs_p0, hit_p0;
    logic [2:0]  xbit_p0;
    logic [3:0]  line_p0;

    logic        vld_p1, vis_p1, hs_p1, vs_p1, hit_p1;
    logic [2:0]  xbit_p1;
    logic [3:0]  fg_p1, bg_p1;

    logic [3:0]  colour_p2;
    logic        vis_p2, hs_p2, vs_p2;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          pixel;

    // Stage 0: cell coordinates, text RAM request
    assign col     = hcount[15:3];
    assign row     = vcount[15:4];
    assign line    = vcount[3:0];
    assign in_text = hvis & vvis & (row < 12'(ROWS)) & (col < 13'(COLS));
    assign hit     = cursor_en & (col == {6'd0, cursor_col}) & (row == {6'd0, cursor_row})
                     & (line >= 4'd14);

    assign text_re   = pix_en & ~nrst & in_text;
    assign text_addr = row * 12'(COLS) + col[11:0];

    // Stage 1: attribute word arrives, font ROM request
    assign font_re   = pix_en & ~nrst & vld_p0;
    assign font_addr = {text_data[7:0], line_p0};

    // Stage 2: glyph row arrives, pixel select
    assign pixel = font_data[3'd7 - xbit_p1] | (hit_p1 & blink_phase);

    always_ff @(posedge clk) begin
        if (nrst) begin
            vld_p0    <= 1'b0;
            vis_p0    <= 1'b0;
            hs_p0     <= 1'b0;
            vs_p0     <= 1'b0;
            hit_p0    <= 1'b0;
            xbit_p0   <= '0;
            line_p0   <= '0;
            vld_p1    <= 1'b0;
            vis_p1    <= 1'b0;
            hs_p1     <= 1'b0;
            vs_p1     <= 1'b0;
            hit_p1    <= 1'b0;
            xbit_p1   <= '0;
            fg_p1     <= '0;
            bg_p1     <= '0;
            colour_p2 <= '0;
            vis_p2    <= 1'b0;
            hs_p2     <= 1'b0;
            vs_p2     <= 1'b0;
        end else if (pix_en) begin
            vld_p0    <= in_text;
            vis_p0    <= hvis & vvis;
            hs_p0     <= hsync_in;
            vs_p0     <= vsync_in;
            hit_p0    <= hit;
            xbit_p0   <= hcount[2:0];
            line_p0   <= line;

            vld_p1    <= vld_p0;
            vis_p1    <= vis_p0;
            hs_p1     <= hs_p0;
            vs_p1     <= vs_p0;
            hit_p1    <= hit_p0;
            xbit_p1   <= xbit_p0;
            fg_p1     <= text_data[11:8];
            bg_p1     <= text_data[15:12];

            colour_p2 <= pick_colour(vld_p1, pixel, fg_p1, bg_p1);
            vis_p2    <= vis_p1;
            hs_p2     <= hs_p1;
            vs_p2     <= vs_p1;
        end
    end

    // vs_p1 is vs_p0 one strobe earlier, so this catches the stage-0 vsync rising edge
    always_ff @(posedge clk) begin
        if (nrst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (pix_en && vs_p0 && !vs_p1) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign colour    = colour_p2;
    assign hsync_out = hs_p2;
    assign vsync_out = vs_p2;
    assign vis_out   = vis_p2;

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer: behavioural text RAM / font ROM, table-driven vectors
// plus sequences for reset, strobe gaps, sync alignment and cursor blink.
module tb_text_renderer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        pix_en;
    logic [15:0] hcount, vcount;
    logic        hvis, vvis, hsync_in, vsync_in;
    logic        text_re, font_re;
    logic [11:0] text_addr, font_addr;
    logic [15:0] text_data = '0;
    logic [7:0]  font_data = '0;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [3:0]  colour;
    logic        hsync_out, vsync_out, vis_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] tram [4096];
    logic [7:0]  fram [4096];

    text_renderer dut (
        .clk(clk), .nrst(nrst), .pix_en(pix_en),
        .hcount(hcount), .vcount(vcount), .hvis(hvis), .vvis(vvis),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .text_re(text_re), .text_addr(text_addr), .text_data(text_data),
        .font_re(font_re), .font_addr(font_addr), .font_data(font_data),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .colour(colour), .hsync_out(hsync_out), .vsync_out(vsync_out), .vis_out(vis_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (text_re) text_data <= tram[text_addr];
        if (font_re) font_data <= fram[font_addr];
    end

    typedef struct {
        logic [15:0] h, v;
        logic        hv, vv, hs, vs;
        logic        tre;
        logic [11:0] taddr;
        logic        fre;
        logic [11:0] faddr;
        logic [3:0]  col;
        logic        evis, ehs, evs;
    } vec_t;

    localparam int N = 18;
    vec_t tbl [N];
    vec_t idle;

    function automatic vec_t mk(int h, int v, bit hv, bit vv, bit hs, bit vs,
                                bit tre, int taddr, bit fre, int faddr,
                                int c, bit evis, bit ehs, bit evs);
        vec_t r;
        r.h = 16'(h);  r.v = 16'(v);
        r.hv = hv; r.vv = vv; r.hs = hs; r.vs = vs;
        r.tre = tre; r.taddr = 12'(taddr);
        r.fre = fre; r.faddr = 12'(faddr);
        r.col = 4'(c); r.evis = evis; r.ehs = ehs; r.evs = evs;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        hcount = x.h; vcount = x.v; hvis = x.hv; vvis = x.vv;
        hsync_in = x.hs; vsync_in = x.vs;
    endtask

    task automatic strobe(input vec_t x);
        apply(x);
        pix_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_out(input string tag, input vec_t x);
        chk({tag, " colour"}, 32'(colour), 32'(x.col));
        chk({tag, " vis_out"}, 32'(vis_out), 32'(x.evis));
        chk({tag, " hsync_out"}, 32'(hsync_out), 32'(x.ehs));
        chk({tag, " vsync_out"}, 32'(vsync_out), 32'(x.evs));
    endtask

    task automatic run_table(input bit gaps);
        vec_t cur;
        string tag;
        for (int k = 0; k < N + 2; k++) begin
            cur = (k < N) ? tbl[k] : idle;
            apply(cur);
            pix_en = 1'b1;
            #1;
            if (k < N) begin
                tag = $sformatf("vec%0d g%0d", k, gaps);
                chk({tag, " text_re"}, 32'(text_re), 32'(cur.tre));
                if (cur.tre) chk({tag, " text_addr"}, 32'(text_addr), 32'(cur.taddr));
            end
            if (k >= 1 && k <= N) begin
                tag = $sformatf("vec%0d g%0d", k - 1, gaps);
                chk({tag, " font_re"}, 32'(font_re), 32'(tbl[k-1].fre));
                if (tbl[k-1].fre) chk({tag, " font_addr"}, 32'(font_addr), 32'(tbl[k-1].faddr));
            end
            @(posedge clk); #1;
            if (k >= 2) check_out($sformatf("out vec%0d g%0d", k - 2, gaps), tbl[k-2]);
            if (gaps) begin
                pix_en = 1'b0;
                #1;
                chk($sformatf("gap%0d text_re", k), 32'(text_re), 32'd0);
                chk($sformatf("gap%0d font_re", k), 32'(font_re), 32'd0);
                @(posedge clk); #1;
                if (k >= 2) check_out($sformatf("hold vec%0d", k - 2), tbl[k-2]);
            end
        end
        pix_en = 1'b0;
    endtask

    task automatic pix_check(input string nm, input int h, input int v, input int exp);
        strobe(mk(h, v, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        strobe(idle);
        strobe(idle);
        chk(nm, 32'(colour), 32'(exp));
        pix_en = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            strobe(mk(0, 601, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            strobe(idle);
        end
        pix_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int hs_cnt, hs_first, mis, vis_fall;
        bit seen_vis;
        bit hs_hist [300];
        for (int a = 0; a < 4096; a++) begin
            tram[a] = 16'h5C20;
            fram[a] = 8'h00;
        end
        tram[202]   = 16'h2A41;
        fram[12'h413] = 8'h80;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = mk(16,  35, 1, 1, 0, 0, 1, 202,  1, 'h413, 'hA, 1, 0, 0);
        for (int i = 1; i < 8; i++)
            tbl[i] = mk(16 + i, 35, 1, 1, 0, 0, 1, 202, 1, 'h413, 'h2, 1, 0, 0);
        tbl[8]  = mk(24,  35, 1, 1, 0, 0, 1, 203,  1, 'h203, 'h5, 1, 0, 0);
        tbl[9]  = mk(799, 35, 1, 1, 0, 0, 1, 299,  1, 'h203, 'h5, 1, 0, 0);
        tbl[10] = mk(800, 35, 0, 1, 0, 0, 0, 0,    0, 0,     0,   0, 0, 0);
        tbl[11] = mk(800, 35, 1, 1, 0, 0, 0, 0,    0, 0,     0,   1, 0, 0);
        tbl[12] = mk(16, 592, 1, 1, 0, 0, 0, 0,    0, 0,     0,   1, 0, 0);
        tbl[13] = mk(100,599, 1, 1, 0, 0, 0, 0,    0, 0,     0,   1, 0, 0);
        tbl[14] = mk(0,  591, 1, 1, 0, 0, 1, 3600, 1, 'h20F, 'h5, 1, 0, 0);
        tbl[15] = mk(799,591, 1, 1, 0, 0, 1, 3699, 1, 'h20F, 'h5, 1, 0, 0);
        tbl[16] = mk(840, 35, 0, 1, 1, 0, 0, 0,    0, 0,     0,   0, 1, 0);
        tbl[17] = mk(0,  601, 1, 0, 0, 1, 0, 0,    0, 0,     0,   0, 0, 1);

        cursor_en = 1'b0; cursor_col = 7'd5; cursor_row = 6'd1;
        nrst = 1'b1; pix_en = 1'b0;
        apply(idle);
        repeat (2) @(posedge clk);
        #1 nrst = 1'b0;

        // Fill the pipeline, then reset mid-line
        strobe(mk(16, 35, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        strobe(mk(17, 35, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        strobe(mk(18, 35, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("prereset colour", 32'(colour), 32'hA);
        chk("prereset hsync_out", 32'(hsync_out), 32'd1);
        apply(mk(19, 35, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        nrst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset colour", 32'(colour), 32'd0);
        chk("reset hsync_out", 32'(hsync_out), 32'd0);
        chk("reset vsync_out", 32'(vsync_out), 32'd0);
        chk("reset vis_out", 32'(vis_out), 32'd0);
        chk("reset text_re", 32'(text_re), 32'd0);
        chk("reset font_re", 32'(font_re), 32'd0);
        nrst = 1'b0;
        apply(mk(19, 35, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("release vis_out s0", 32'(vis_out), 32'd0);
        strobe(mk(19, 35, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("release vis_out s1", 32'(vis_out), 32'd0);
        strobe(mk(19, 35, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("release vis_out s2", 32'(vis_out), 32'd0);
        strobe(mk(19, 35, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("release vis_out s3", 32'(vis_out), 32'd1);
        chk("release colour s3", 32'(colour), 32'h2);
        pix_en = 1'b0;

        run_table(1'b0);
        run_table(1'b1);

        // One line around the right edge and horizontal sync
        hs_cnt = 0; hs_first = -1; mis = 0; vis_fall = -1; seen_vis = 1'b0;
        for (int k = 0; k < 213; k++) begin
            int h;
            h = 790 + k;
            hs_hist[k] = (k < 211) && (h >= 840) && (h < 968);
            if (k < 211)
                strobe(mk(h, 35, (h < 800), 1, hs_hist[k], 0, 0, 0, 0, 0, 0, 0, 0, 0));
            else
                strobe(idle);
            if (hsync_out) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
            if (k >= 2 && hsync_out !== hs_hist[k-2]) mis++;
            if (vis_out) seen_vis = 1'b1;
            else if (seen_vis && vis_fall < 0) vis_fall = k;
        end
        pix_en = 1'b0;
        chk("sync hsync_out width", 32'(hs_cnt), 32'd128);
        chk("sync hsync_out first", 32'(hs_first), 32'd52);
        chk("sync hsync_out misaligned", 32'(mis), 32'd0);
        chk("sync vis_out fall", 32'(vis_fall), 32'd12);

        // Cursor blink from a fresh reset
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b0;
        cursor_en = 1'b1;
        pix_check("cursor ph0 l14", 40, 30, 'h5);
        frames(29);
        pix_check("cursor frame29 l15", 47, 31, 'h5);
        frames(1);
        pix_check("cursor ph1 l14", 40, 30, 'hC);
        pix_check("cursor ph1 l15", 47, 31, 'hC);
        pix_check("cursor ph1 col6", 48, 30, 'h5);
        pix_check("cursor ph1 l13", 40, 29, 'h5);
        frames(29);
        pix_check("cursor frame59", 44, 31, 'hC);
        frames(1);
        pix_check("cursor frame60", 44, 31, 'h5);
        cursor_en = 1'b0;
        frames(30);
        pix_check("cursor disabled", 40, 30, 'h5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_renderer.md
Name: text_renderer

Overview:
- Character-mode pixel generator that sits directly downstream of the horizontal/vertical timing generators in the 800x600 SVGA path.
- Consumes pixel/line counts, visibility and positive sync pulses, and fetches character/attribute words from text RAM and glyph rows from font ROM.
- Emits a 4-bit colour index with sync and visibility delayed to match.
- Fixed 8x16 character cell; optional blinking underline cursor.

Parameters:
- COLS, 100, characters per row (800/8)
- ROWS, 37, character rows (37*16 = 592 lines)
- BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-high
- pix_en  in  1  pixel advance strobe; the pipeline moves only when 1
- hcount  in  16  horizontal count
- vcount  in  16  vertical count
- hvis  in  1  horizontal visible
- vvis  in  1  vertical visible
- hsync_in  in  1  horizontal sync, positive
- vsync_in  in  1  vertical sync, positive
- text_re  out  1  text RAM read enable
- text_addr  out  12  text RAM address
- text_data  in  16  [7:0] char code, [11:8] fg, [15:12] bg; valid the cycle after text_re, held until the next read
- font_re  out  1  font ROM read enable
- font_addr  out  12  {char code, glyph line[3:0]}
- font_data  in  8  glyph row, bit 7 = leftmost pixel; same timing as text_data
- cursor_en  in  1  cursor enable
- cursor_col  in  7  cursor column
- cursor_row  in  6  cursor row
- colour  out  4  pixel colour index
- hsync_out  out  1  delayed hsync
- vsync_out  out  1  delayed vsync
- vis_out  out  1  delayed visibility

Behaviour:
- Reset (nrst=1 at a clk edge) clears all pipeline registers, valid bits, blink counter and blink phase to 0. All outputs are 0 the next cycle. Reset mid-frame flushes the pipeline.
- pix_en=0: every register holds, and text_re/font_re are 0.
- Stage 0 (pix_en=1):
  - col = hcount>>3, line = vcount[3:0], row = vcount>>4, in_text = hvis & vvis & (row < ROWS) & (col < COLS).
  - text_re = in_text; text_addr = row*COLS + col, truncated to 12 bits (max 3699).
  - Register in_text, vis = hvis&vvis, hcount[2:0], line, hsync_in, vsync_in, and cursor hit = cursor_en & col==cursor_col & row==cursor_row & line>=14.
- Stage 1 (next pix_en):
  - font_re = stage-0 in_text; font_addr = {text_data[7:0], line}.
  - Register fg/bg from text_data and shift all stage-0 side bits forward.
- Stage 2 (next pix_en):
  - pixel = font_data[7 - xbit] | (cursor hit & blink phase).
  - colour = in_text ? (pixel ? fg : bg) : 0.
  - hsync_out, vsync_out and vis_out are registered together with colour.
- Latency: exactly 3 pix_en strobes from inputs to outputs. Sync and vis stay aligned with colour.
- Visible lines 592–599 and any out-of-range column give colour 0, with no RAM/ROM reads.
- Blink:
  - A rising edge of stage-0 registered vsync increments the frame counter.
  - At BLINK_FRAMES-1 the counter wraps to 0 and the phase toggles.
  - The cursor is shown only when phase=1.
- Reads are not speculative outside the visible region; memory outputs hold between enables.

Test Plan:
- Reset: nrst=1 for 5 cycles mid-line → colour=0, hsync_out=vsync_out=vis_out=0, text_re=font_re=0. After release, the first 3 pix_en give vis_out=0.
- Fetch path: hcount=16, vcount=35, visible → text_addr=202 with text_re=1. Return 0x2A41 → font_addr=0x413. Return font_data=0x80 → colour=0xA on the 3rd pix_en, then colour=0x2 for hcount=17..23.
- Sync alignment: hsync_in high for hcount 840..967 → hsync_out high for exactly 128 strobes, 3 strobes later; vis_out falls 3 strobes after hvis.
- Bottom band: vcount 592..599 with vvis=1 → text_re=0, colour=0, vis_out=1.
- Strobe gaps: pix_en every other cycle → output sequence identical to the continuous run, and outputs hold on pix_en=0 cycles.
- Cursor: cursor_en=1, col 5, row 1, font_data=0 → lines 30..31, hcount 40..47 show fg during phase 1 (frames 30..59 after reset) and bg during phase 0.
